// File: rtl/dma_copy.sv
`timescale 1ns/1ps
// dma_copy: word-granular DMA copy/fill engine mastering the CPU data bus.
//
// Control side:
//   start, fill_mode, src_addr, dst_addr, fill_value, word_count  - sampled
//       only on a start accepted in IDLE.
//   abort   - level, honoured when the outstanding transaction acks.
//   busy, done, error, aborted - status (done is a one-cycle pulse; error and
//       aborted are sticky until the next accepted start).
// Bus side (one-cycle request, single ack, one transaction in flight):
//   bus_request, bus_addr, bus_write, bus_byte_enable, bus_wdata - outputs.
//   bus_rdata, bus_ack - responder completion.
//
// All outputs come straight from flops. bus_wdata_q doubles as the data
// register that carries a read word over to the following write.
module dma_copy #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        fill_mode,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [31:0] fill_value,
    input  logic [15:0] word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        aborted,
    output logic        bus_request,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
    } state_t;

    // Last wait-counter value before the transaction is declared dead.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] count_q, count_d;
    logic        fill_q, fill_d;
    logic [31:0] fill_val_q, fill_val_d;
    logic [7:0]  wait_q, wait_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        aborted_q, aborted_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        aborted_d  = aborted_q;
        req_d      = 1'b0;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d      = src_addr & WORD_MASK;
                    dst_d      = dst_addr & WORD_MASK;
                    count_d    = word_count;
                    fill_d     = fill_mode;
                    fill_val_d = fill_value;
                    error_d    = 1'b0;
                    aborted_d  = 1'b0;
                    busy_d     = 1'b1;
                    if (word_count == 16'd0) begin
                        // Empty transfer: busy and done share the one cycle.
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else if (fill_mode) begin
                        req_d   = 1'b1;
                        write_d = 1'b1;
                        addr_d  = dst_addr & WORD_MASK;
                        wdata_d = fill_value;
                        state_d = WR_REQ;
                    end else begin
                        req_d   = 1'b1;
                        write_d = 1'b0;
                        addr_d  = src_addr & WORD_MASK;
                        state_d = RD_REQ;
                    end
                end
            end
            // Request is on the bus this cycle; start the ack timer.
            RD_REQ: begin
                wait_d  = 8'd0;
                state_d = RD_WAIT;
            end
            WR_REQ: begin
                wait_d  = 8'd0;
                state_d = WR_WAIT;
            end
            RD_WAIT: begin
                if (bus_ack) begin
                    src_d = src_q + 32'd4;
                    if (abort) begin
                        // Drop the pending write; the read word is discarded.
                        aborted_d = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = FINISH;
                    end else begin
                        req_d   = 1'b1;
                        write_d = 1'b1;
                        addr_d  = dst_q;
                        wdata_d = bus_rdata;
                        state_d = WR_REQ;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR_WAIT: begin
                if (bus_ack) begin
                    dst_d   = dst_q + 32'd4;
                    count_d = count_q - 16'd1;
                    if (abort) aborted_d = 1'b1;
                    if (count_q == 16'd1 || abort) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end else if (fill_q) begin
                        req_d   = 1'b1;
                        write_d = 1'b1;
                        addr_d  = dst_q + 32'd4;
                        wdata_d = fill_val_q;
                        state_d = WR_REQ;
                    end else begin
                        req_d   = 1'b1;
                        write_d = 1'b0;
                        addr_d  = src_q;
                        state_d = RD_REQ;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            fill_q     <= 1'b0;
            fill_val_q <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            aborted_q  <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            aborted_q  <= aborted_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign aborted         = aborted_q;
    assign bus_request     = req_q;
    assign bus_addr        = addr_q;
    assign bus_write       = write_q;
    assign bus_byte_enable = 4'b1111;
    assign bus_wdata       = wdata_q;

endmodule

// File: tb/tb_dma_copy.sv
`timescale 1ns/1ps
// Bench for dma_copy: a bus responder acks each request one cycle later and
// checks every request against a queue of expected transactions pushed when
// the transfer is started. Scenario tasks check status and timing inline.
module tb_dma_copy;
    localparam int TO = 8;

    logic        clock, reset, start, fill_mode, abort, bus_ack;
    logic [31:0] src_addr, dst_addr, fill_value, bus_rdata;
    logic [15:0] word_count;
    logic        busy, done, error, aborted, bus_request, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_byte_enable;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   req_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   req_cnt = 0;
    int   rd_seen = 0;
    int   drop_read_n = -1;
    int   stray_ack_cyc = -1;

    dma_copy #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .fill_mode(fill_mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .fill_value(fill_value),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .error(error), .aborted(aborted), .bus_request(bus_request),
        .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_byte_enable(bus_byte_enable), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    // Responder + scoreboard. Samples at #1 after the edge; tasks use #2.
    initial begin : responder
        logic        pend, pend_rd;
        logic [31:0] pend_addr;
        txn_t        e;
        pend = 1'b0; pend_rd = 1'b0; pend_addr = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            bus_ack = 1'b0;
            if (reset !== 1'b1) pend = 1'b0;
            if (pend) begin
                pend = 1'b0;
                if (!(pend_rd && rd_seen == drop_read_n)) begin
                    bus_ack   = 1'b1;
                    bus_rdata = pend_rd ? rd_of(pend_addr) : 32'h0;
                end
            end
            if (cyc == stray_ack_cyc) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hBAD0_BAD0;
            end
            if (reset === 1'b1 && bus_request === 1'b1) begin
                req_cyc.push_back(cyc);
                req_cnt++;
                if (bus_write !== 1'b1) rd_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_req: cyc=%0d got addr=%h write=%b, required no request",
                             cyc, bus_addr, bus_write);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_addr !== e.addr || bus_write !== e.wr ||
                        (e.wr && bus_wdata !== e.data) || bus_byte_enable !== 4'hF) begin
                        failures++;
                        $display("FAIL sb_txn: cyc=%0d got addr=%h wr=%b wdata=%h be=%b, required addr=%h wr=%b wdata=%h be=1111",
                                 cyc, bus_addr, bus_write, bus_wdata, bus_byte_enable, e.addr, e.wr, e.data);
                    end
                end
                pend      = 1'b1;
                pend_rd   = (bus_write !== 1'b1);
                pend_addr = bus_addr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.wr = w; t.data = d;
        exp_q.push_back(t);
    endtask

    // One-cycle start; afterwards config inputs are scrambled so that only
    // the values latched at the accepted start can matter.
    task automatic do_start(input logic fm, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] fv, input logic [15:0] n);
        fill_mode = fm; src_addr = s; dst_addr = d; fill_value = fv; word_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        src_addr = $urandom; dst_addr = $urandom; fill_value = $urandom;
        word_count = 16'($urandom); fill_mode = ~fm;
    endtask

    task automatic wait_done(input int budget, output int at);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        at = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, done, error, aborted, bus_request, bus_write} !== 6'b0) begin
            failures++;
            $display("FAIL reset_status: got busy/done/err/abt/req/wr=%b required 000000",
                     {busy, done, error, aborted, bus_request, bus_write});
        end
        checks++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h wdata=%h required 0/0", bus_addr, bus_wdata);
        end
        checks++;
        if (bus_byte_enable !== 4'b1111) begin
            failures++;
            $display("FAIL reset_be: got %b required 1111", bus_byte_enable);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_copy();
        int n0, t_done;
        n0 = req_cnt;
        for (int i = 0; i < 3; i++) begin
            push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            push(32'h2000 + 32'(4 * i), 1'b1, rd_of(32'h1000 + 32'(4 * i)));
        end
        do_start(1'b0, 32'h1000, 32'h2000, 32'h0, 16'd3);
        checks++;
        if (busy !== 1'b1 || bus_request !== 1'b1) begin
            failures++;
            $display("FAIL copy_start: got busy=%b req=%b required 1/1", busy, bus_request);
        end
        wait_done(60, t_done);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL copy_done_timeout: got done=%b required 1", done);
        end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || aborted !== 1'b0) begin
            failures++;
            $display("FAIL copy_status: got busy=%b err=%b abt=%b required 0/0/0", busy, error, aborted);
        end
        checks++;
        if (req_cnt != n0 + 6) begin
            failures++;
            $display("FAIL copy_req_count: got %0d required 6", req_cnt - n0);
        end else begin
            checks++;
            if (t_done - req_cyc[n0] != 12) begin
                failures++;
                $display("FAIL copy_latency: got %0d required 12", t_done - req_cyc[n0]);
            end
            checks++;
            if (req_cyc[n0 + 2] - req_cyc[n0] != 4) begin
                failures++;
                $display("FAIL copy_word_period: got %0d required 4", req_cyc[n0 + 2] - req_cyc[n0]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL copy_done_pulse: got done=%b required 0", done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL copy_missing: got %0d unissued required 0", exp_q.size());
        end
    endtask

    task automatic test_fill();
        int n0, t_done;
        n0 = req_cnt;
        push(32'hFFFF_FFFC, 1'b1, 32'hDEAD_BEEF);
        push(32'h0000_0000, 1'b1, 32'hDEAD_BEEF);
        do_start(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 16'd2);
        wait_done(30, t_done);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL fill_done: got done=%b err=%b required 1/0", done, error);
        end
        checks++;
        if (req_cnt != n0 + 2) begin
            failures++;
            $display("FAIL fill_req_count: got %0d required 2", req_cnt - n0);
        end else begin
            checks++;
            if (req_cyc[n0 + 1] - req_cyc[n0] != 2 || t_done - req_cyc[n0] != 4) begin
                failures++;
                $display("FAIL fill_timing: got period=%0d latency=%0d required 2/4",
                         req_cyc[n0 + 1] - req_cyc[n0], t_done - req_cyc[n0]);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL fill_missing: got %0d unissued required 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_zero_count();
        int n0;
        n0 = req_cnt;
        do_start(1'b0, 32'h100, 32'h200, 32'h0, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || bus_request !== 1'b0) begin
            failures++;
            $display("FAIL zero_t1: got done=%b busy=%b req=%b required 1/1/0", done, busy, bus_request);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_t2: got done=%b busy=%b required 0/0", done, busy);
        end
        repeat (3) tick();
        checks++;
        if (req_cnt != n0) begin
            failures++;
            $display("FAIL zero_no_bus: got %0d requests required 0", req_cnt - n0);
        end
    endtask

    task automatic test_timeout();
        int n0, t_done;
        n0 = req_cnt;
        drop_read_n = rd_seen + 2;
        push(32'h3000, 1'b0, 32'h0);
        push(32'h4000, 1'b1, rd_of(32'h3000));
        push(32'h3004, 1'b0, 32'h0);
        do_start(1'b0, 32'h3000, 32'h4000, 32'h0, 16'd4);
        wait_done(60, t_done);
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag: got done=%b err=%b required 1/1", done, error);
        end
        checks++;
        if (req_cnt != n0 + 3) begin
            failures++;
            $display("FAIL timeout_req_count: got %0d required 3", req_cnt - n0);
        end else begin
            checks++;
            if (t_done - req_cyc[n0 + 2] != TO + 1) begin
                failures++;
                $display("FAIL timeout_latency: got %0d required %0d", t_done - req_cyc[n0 + 2], TO + 1);
            end
        end
        repeat (4) tick();
        checks++;
        if (req_cnt != n0 + 3 || error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after: got reqs=%0d err=%b busy=%b required 3/1/0", req_cnt - n0, error, busy);
        end
        drop_read_n = -1;
        push(32'h4400, 1'b1, 32'h55AA_33CC);
        do_start(1'b1, 32'h0, 32'h4400, 32'h55AA_33CC, 16'd1);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got err=%b required 0", error);
        end
        wait_done(20, t_done);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_recover: got done=%b err=%b pending=%0d required 1/0/0", done, error, exp_q.size());
        end
        tick();
    endtask

    task automatic test_abort();
        int n0, t_done;
        n0 = req_cnt;
        push(32'h5000, 1'b0, 32'h0);
        push(32'h6000, 1'b1, rd_of(32'h5000));
        push(32'h5004, 1'b0, 32'h0);
        do_start(1'b0, 32'h5000, 32'h6000, 32'h0, 16'd5);
        // A start while busy (empty fill) must change nothing.
        start = 1'b1; fill_mode = 1'b1; word_count = 16'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && req_cnt < n0 + 3; i++) tick();
        abort = 1'b1;
        wait_done(20, t_done);
        abort = 1'b0;
        checks++;
        if (done !== 1'b1 || aborted !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_status: got done=%b abt=%b err=%b busy=%b required 1/1/0/0",
                     done, aborted, error, busy);
        end
        checks++;
        if (req_cnt != n0 + 3) begin
            failures++;
            $display("FAIL abort_req_count: got %0d required 3", req_cnt - n0);
        end else begin
            checks++;
            if (t_done - req_cyc[n0 + 2] != 2) begin
                failures++;
                $display("FAIL abort_latency: got %0d required 2", t_done - req_cyc[n0 + 2]);
            end
        end
        abort = 1'b1;
        repeat (4) tick();
        abort = 1'b0;
        checks++;
        if (req_cnt != n0 + 3 || aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got reqs=%0d abt=%b busy=%b done=%b required 3/1/0/0",
                     req_cnt - n0, aborted, busy, done);
        end
        do_start(1'b0, 32'h0, 32'h0, 32'h0, 16'd0);
        checks++;
        if (aborted !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: got abt=%b required 0", aborted);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n0, n1, t_done;
        n0 = req_cnt;
        push(32'h7000, 1'b0, 32'h0);
        push(32'h8000, 1'b1, rd_of(32'h7000));
        do_start(1'b0, 32'h7000, 32'h8000, 32'h0, 16'd2);
        for (int i = 0; i < 20 && req_cnt < n0 + 2; i++) tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus_request !== 1'b0 || bus_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b req=%b addr=%h required 0/0/0", busy, bus_request, bus_addr);
        end
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        stray_ack_cyc = cyc + 1;
        n1 = req_cnt;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || req_cnt != n1) begin
            failures++;
            $display("FAIL stray_ack: got busy=%b done=%b reqs=%0d required 0/0/0", busy, done, req_cnt - n1);
        end
        stray_ack_cyc = -1;
        for (int i = 0; i < 2; i++) begin
            push(32'h9000 + 32'(4 * i), 1'b0, 32'h0);
            push(32'hA000 + 32'(4 * i), 1'b1, rd_of(32'h9000 + 32'(4 * i)));
        end
        do_start(1'b0, 32'h9000, 32'hA000, 32'h0, 16'd2);
        wait_done(40, t_done);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || aborted !== 1'b0 || req_cnt != n1 + 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_recover: got done=%b err=%b abt=%b reqs=%0d pending=%0d required 1/0/0/4/0",
                     done, error, aborted, req_cnt - n1, exp_q.size());
        end
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; fill_mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; fill_value = '0; word_count = '0;
        test_reset();
        test_copy();
        test_fill();
        test_zero_count();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
# dma_copy

Word-granular DMA copy/fill engine acting as an initiator on the CPU data-bus protocol (one-cycle request, single ack response). It sits alongside the CPU as a second bus master, in front of the bus arbiter, and moves blocks between memory and peripheral registers without CPU involvement. Transfers are configured and started through a sideband control port. It reports busy, a one-cycle done pulse, and error status.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for ack before declaring a bus error; 8-bit counter.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- fill_mode  in  1  0 = copy src→dst; 1 = write fill_value to dst.
- src_addr  in  32  source byte address; bits [1:0] ignored.
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- fill_value  in  32  data written in fill mode.
- word_count  in  16  number of 32-bit words to move.
- abort  in  1  level; stops the transfer after the outstanding transaction.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of transfer (normal, abort or error).
- error  out  1  sticky bus-timeout flag; cleared by next accepted start.
- aborted  out  1  sticky; set when terminated by abort; cleared by next start.
- bus_request  out  1  one-cycle transaction request.
- bus_addr  out  32  word-aligned address, [1:0] = 0.
- bus_write  out  1  1 = write, 0 = read.
- bus_byte_enable  out  4  always 4'b1111.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid when bus_ack is high.
- bus_ack  in  1  responder completion.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE + start: latch src, dst, count, mode, fill_value; clear error/aborted. If count = 0, go to FINISH. Otherwise go to WR_REQ in fill mode, RD_REQ in copy mode.
- RD_REQ: assert bus_request, bus_write = 0, bus_addr = src; → RD_WAIT.
- RD_WAIT: on bus_ack, capture bus_rdata into the data register; src += 4; → WR_REQ.
- WR_REQ: assert bus_request, bus_write = 1, bus_wdata = data register (or fill_value); → WR_WAIT.
- WR_WAIT: on bus_ack, dst += 4 and count −= 1. Then:
  - count now 0 or abort high → FINISH.
  - otherwise → RD_REQ (copy) or WR_REQ (fill).
- FINISH: pulse done; busy low; → IDLE.
- Exactly one outstanding transaction at a time. bus_request is never asserted while waiting.
- Addresses are 32-bit and wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
- Timeout: the wait counter resets on entry to RD_WAIT/WR_WAIT. If TIMEOUT cycles pass with no ack, set error and go to FINISH with no further requests.
- abort:
  - Sampled in RD_WAIT/WR_WAIT on ack. If high, set aborted and go to FINISH.
  - An abort seen on a read ack skips the pending write.
  - abort is ignored in IDLE.
- bus_ack in IDLE, RD_REQ, WR_REQ or FINISH is ignored.
- start while busy is ignored; configuration inputs are only sampled at the accepted start.

## Timing
- Reset values: busy 0, done 0, error 0, aborted 0, bus_request 0, bus_write 0, bus_addr 0, bus_wdata 0, bus_byte_enable 4'b1111. State is IDLE.
- Reset assertion takes effect immediately, including mid-transfer; the transfer is lost.
- All outputs are registered.
- Start accepted at cycle T:
  - busy rises at T+1.
  - First bus_request at T+1.
  - count = 0: done at T+1 with no bus traffic.
- With a responder acking one cycle after request:
  - copy: 4 cycles per word.
  - fill: 2 cycles per word.
- The next request is issued the cycle after the ack.
- done pulses the cycle after the final ack; busy falls with done.
- A new start is accepted the cycle after done.
- With TIMEOUT = N, error and done assert N+1 cycles after the unacked request.

## Test plan
- Copy 3 words, src 0x1000, dst 0x2000, 1-cycle ack → sequence R1000, W2000, R1004, W2004, R1008, W2008 with data preserved; done 12 cycles after first request; error 0.
- Fill 2 words of 0xDEADBEEF at dst 0xFFFFFFFC → writes to 0xFFFFFFFC then 0x00000000 (wrap); 2 cycles per word; byte_enable 1111.
- word_count 0 → done at T+1; bus_request never asserted; busy high for exactly that cycle.
- Responder never acks the second read, TIMEOUT = 8 → error set, done pulse, no further requests; a subsequent start clears error.
- abort raised during the read of word 2 of 5 → that read completes, no write follows, aborted = 1, done pulses; start pulses during busy are ignored.
- reset asserted in WR_WAIT → bus_request/busy drop immediately; after release, a stray bus_ack is ignored and a new copy runs cleanly.
